ltch_bank: RTL and testbench

LTCH_BANK -- requirements
Module: ltch_bank

---
 rtl/ltch_bank.sv | 142 ++++++++++++++
 tb/tb_ltch_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ltch_bank.sv
// ltch_bank: per-channel capture latch bank with valid/change flags and a snapshot handshake.
// Optional saturating per-channel capture counters (port cnt_o) exist only with LTCH_BANK_CNT_EN.
module ltch_bank #(
  parameter int unsigned DW        = 8,
  parameter int unsigned NCH       = 4,
  parameter int unsigned CNT_W     = 8,
  parameter string       LTCH_NAME = "ltch_bank"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    en_i,
  input  logic [NCH*DW-1:0] data_i,
  input  logic              frz_i,
  input  logic              clr_i,
  output logic [NCH*DW-1:0] data_o,
  output logic [NCH-1:0]    vld_o,
  output logic [NCH-1:0]    chg_o,
  input  logic              snap_req_i,
  output logic              snap_vld_o,
  input  logic              snap_rdy_i,
  output logic [NCH*DW-1:0] snap_data_o
`ifdef LTCH_BANK_CNT_EN
  ,
  output logic [NCH*CNT_W-1:0] cnt_o
`endif
);

  if (DW < 1 || NCH < 1 || CNT_W < 2) begin : g_param_chk
    $error("ltch_bank: DW, NCH must be >= 1 and CNT_W >= 2");
  end

  logic [NCH*DW-1:0] data_q, data_d;
  logic [NCH-1:0]    vld_q, vld_d;
  logic [NCH-1:0]    chg_q, chg_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    chg_d  = '0;
    if (clr_i) begin
      data_d = '0;
      vld_d  = '0;
    end else if (!frz_i) begin
      for (int k = 0; k < NCH; k++) begin
        if (en_i[k]) begin
          // First capture after reset/clear always flags a change.
          chg_d[k] = !vld_q[k] || (data_i[k*DW +: DW] != data_q[k*DW +: DW]);
          data_d[k*DW +: DW] = data_i[k*DW +: DW];
          vld_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= '0;
      chg_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      chg_q  <= chg_d;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;
  assign chg_o  = chg_q;

`ifdef LTCH_BANK_CNT_EN
  logic [NCH*CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!frz_i) begin
      for (int k = 0; k < NCH; k++) begin
        if (en_i[k] && (cnt_q[k*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

  typedef enum logic [1:0] {StIdle, StCapt, StHold} snap_st_e;

  snap_st_e          st_q, st_d;
  logic              snap_load;
  logic [NCH*DW-1:0] snap_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:  if (snap_req_i) st_d = StCapt;
      StCapt:  st_d = StHold;
      StHold:  if (snap_rdy_i) st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    snap_vld_o = (st_q == StHold);
    snap_load  = (st_q == StCapt);
  end

  // Loads the pre-edge data_q, so a same-edge capture is excluded; clr_i has no effect here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_data_q <= '0;
    end else if (snap_load) begin
      snap_data_q <= data_q;
    end
  end

  assign snap_data_o = snap_data_q;

  snap_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
    (st_q == StHold && !snap_rdy_i) |=> $stable(snap_data_q))
    else $error("%s: snap_data_o changed while held", LTCH_NAME);

endmodule

// File: tb/tb_ltch_bank.sv
// Self-checking bench for ltch_bank: a behavioural model pushes expected outputs per cycle to a
// scoreboard queue, popped and compared after each clock edge. Counter checks with LTCH_BANK_CNT_EN.
module tb_ltch_bank;
  localparam int unsigned DW    = 8;
  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned W     = NCH * DW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       en_i = '0;
  logic [W-1:0]         data_i = '0;
  logic                 frz_i = 1'b0;
  logic                 clr_i = 1'b0;
  logic [W-1:0]         data_o;
  logic [NCH-1:0]       vld_o;
  logic [NCH-1:0]       chg_o;
  logic                 snap_req_i = 1'b0;
  logic                 snap_vld_o;
  logic                 snap_rdy_i = 1'b0;
  logic [W-1:0]         snap_data_o;
  logic [NCH*CNT_W-1:0] cnt_o;

  always #5 clk = ~clk;

  ltch_bank #(
    .DW       (DW),
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .LTCH_NAME("dut")
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .data_i     (data_i),
    .frz_i      (frz_i),
    .clr_i      (clr_i),
    .data_o     (data_o),
    .vld_o      (vld_o),
    .chg_o      (chg_o),
    .snap_req_i (snap_req_i),
    .snap_vld_o (snap_vld_o),
    .snap_rdy_i (snap_rdy_i),
    .snap_data_o(snap_data_o)
`ifdef LTCH_BANK_CNT_EN
    ,
    .cnt_o      (cnt_o)
`endif
  );

`ifndef LTCH_BANK_CNT_EN
  assign cnt_o = '0;
`endif

  typedef struct {
    logic [W-1:0]         data;
    logic [NCH-1:0]       vld;
    logic [NCH-1:0]       chg;
    logic                 svld;
    logic [W-1:0]         sdata;
    logic [NCH*CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state; m_st: 0 idle, 1 capture, 2 hold.
  logic [DW-1:0] m_data[NCH];
  logic          m_vld[NCH];
  int            m_cnt[NCH];
  int            m_st;
  logic [W-1:0]  m_snap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_data();
    logic [W-1:0] p;
    for (int k = 0; k < NCH; k++) p[k*DW +: DW] = m_data[k];
    return p;
  endfunction

  function automatic logic [NCH*CNT_W-1:0] pack_cnt();
    logic [NCH*CNT_W-1:0] p;
    for (int k = 0; k < NCH; k++) p[k*CNT_W +: CNT_W] = m_cnt[k][CNT_W-1:0];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_data[k] = '0;
      m_vld[k]  = 1'b0;
      m_cnt[k]  = 0;
    end
    m_st   = 0;
    m_snap = '0;
  endtask

  // Drive one cycle of inputs, push the model's prediction, clock, pop and compare.
  task automatic step(input logic [NCH-1:0] en, input logic [W-1:0] d, input logic frz,
                      input logic clr, input logic req, input logic rdy);
    exp_t         e;
    exp_t         got;
    logic [W-1:0] old;
    en_i = en; data_i = d; frz_i = frz; clr_i = clr; snap_req_i = req; snap_rdy_i = rdy;
    old   = pack_data();
    e.chg = '0;
    for (int k = 0; k < NCH; k++) begin
      if (clr) begin
        m_data[k] = '0;
        m_vld[k]  = 1'b0;
        m_cnt[k]  = 0;
      end else if (en[k] && !frz) begin
        e.chg[k]  = !m_vld[k] || (m_data[k] != d[k*DW +: DW]);
        m_data[k] = d[k*DW +: DW];
        m_vld[k]  = 1'b1;
        if (m_cnt[k] < (1 << CNT_W) - 1) m_cnt[k]++;
      end
    end
    case (m_st)
      0: if (req) m_st = 1;
      1: begin m_snap = old; m_st = 2; end
      default: if (rdy) m_st = 0;
    endcase
    e.data = pack_data();
    for (int k = 0; k < NCH; k++) e.vld[k] = m_vld[k];
    e.svld  = (m_st == 2);
    e.sdata = m_snap;
    e.cnt   = pack_cnt();
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("data_o", data_o, got.data);
    check("vld_o", vld_o, got.vld);
    check("chg_o", chg_o, got.chg);
    check("snap_vld_o", snap_vld_o, got.svld);
    check("snap_data_o", snap_data_o, got.sdata);
`ifdef LTCH_BANK_CNT_EN
    check("cnt_o", cnt_o, got.cnt);
`endif
  endtask

  task automatic idle(input logic rdy);
    step('0, '0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    model_reset();
    #2;
    check("rst data_o", data_o, 0);
    check("rst vld_o", vld_o, 0);
    check("rst chg_o", chg_o, 0);
    check("rst snap_vld_o", snap_vld_o, 0);
    check("rst snap_data_o", snap_data_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two channels captured, then a quiet cycle ends the change pulse.
    step(4'b0101, 32'hDDCCBBAA, 1'b0, 1'b0, 1'b0, 1'b0);
    check("first data_o", data_o, 32'h00CC00AA);
    check("first vld_o", vld_o, 4'b0101);
    check("first chg_o", chg_o, 4'b0101);
    idle(1'b0);
    check("chg one cycle", chg_o, 4'b0000);

    // Same value recapture: no change flag; new value: one-cycle pulse.
    step(4'b0001, 32'h000000AA, 1'b0, 1'b0, 1'b0, 1'b0);
    check("same chg_o", chg_o, 4'b0000);
    step(4'b0001, 32'h00000055, 1'b0, 1'b0, 1'b0, 1'b0);
    check("diff chg_o", chg_o, 4'b0001);
    check("diff data_o", data_o, 32'h00CC0055);
    idle(1'b0);

    // Freeze dominates enable; clear dominates capture.
    step(4'hF, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0);
    check("frz data_o", data_o, 32'h00CC0055);
    step(4'hF, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clr data_o", data_o, 0);
    check("clr vld_o", vld_o, 0);

    // Snapshot held for several cycles while ch1 is recaptured on the capture edge.
    step(4'hF, 32'h44332211, 1'b0, 1'b0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'b0010, 32'h00009900, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    check("snap held vld", snap_vld_o, 1'b1);
    check("snap pre-capture", snap_data_o, 32'h44332211);
    check("data after recap", data_o, 32'h44339911);
    idle(1'b1);
    check("snap drop", snap_vld_o, 1'b0);

    // Request held high across the handshake restarts a snapshot.
    for (int i = 0; i < 6; i++) step('0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Asynchronous reset in the middle of HOLD.
    step(4'hF, 32'hA1B2C3D4, 1'b0, 1'b0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre-rst hold", snap_vld_o, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst snap_vld_o", snap_vld_o, 1'b0);
    check("async rst data_o", data_o, 0);
    check("async rst snap_data_o", snap_data_o, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b0);

    // Counter saturation on ch2.
    for (int i = 0; i < 5; i++) step(4'b0100, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef LTCH_BANK_CNT_EN
    check("cnt sat ch2", cnt_o[2*CNT_W +: CNT_W], 3);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      step(4'($urandom), $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
           1'($urandom), 1'($urandom));
    end

    check("sb empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
